// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, reset constants and enums for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC  = 9'h000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_register.sv
// ============================================================================
// Module   : pc_register
// Purpose  : Program counter with next-PC select (hold / +4 / aligned target).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_register
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_t           pc_sel_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // The +4 is left to wrap at the address width; no overflow is reported.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel_i)
            PC_INC:    pc_d = pc_q + ADDR_W'(4);
            PC_TARGET: pc_d = word_align(target_i);
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with stall/branch handling and IF/ID register.
//            Optional perf counters when FETCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus4,
    output logic [1:0]         fetch_state
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_bubbles
`endif
);

    fetch_state_t       state_q, state_d;
    pc_sel_t            pc_sel;
    logic               capture;
    logic               flush;
    logic [ADDR_W-1:0]  pc;

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  ifpc_q;
    logic [ADDR_W-1:0]  ifpc4_q;

    pc_register u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_sel_i (pc_sel),
        .target_i (branch_target),
        .pc_o     (pc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch outranks stall; BOOT ignores both.
    always_comb begin
        state_d = state_q;
        pc_sel  = PC_HOLD;
        capture = 1'b0;
        flush   = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                if (branch_taken) begin
                    flush   = 1'b1;
                    pc_sel  = PC_TARGET;
                    state_d = RUN;
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    capture = 1'b1;
                    pc_sel  = PC_INC;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (capture) begin
            valid_q <= 1'b1;
            instr_q <= imem_instr;
            ifpc_q  <= pc;
            ifpc4_q <= pc + ADDR_W'(4);
        end
    end

    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ifpc_q;
    assign if_id_pc_plus4 = ifpc4_q;
    assign fetch_state    = state_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetched_q;
    logic [15:0] bubbles_q;
    logic        active;

    assign active = (state_q == RUN) || (state_q == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (capture && (fetched_q != 16'hFFFF)) begin
                fetched_q <= fetched_q + 16'd1;
            end
            if (active && !capture && (bubbles_q != 16'hFFFF)) begin
                bubbles_q <= bubbles_q + 16'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench: directed scenarios plus randomized stall,
//            branch and reset traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [8:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [8:0]  branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [8:0]  if_id_pc;
    logic [8:0]  if_id_pc_plus4;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_bubbles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    logic [31:0] mem [0:127];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .fetch_state    (fetch_state)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    // Asynchronous instruction memory, word-indexed.
    assign imem_instr = mem[imem_addr[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: what the pipeline register must hold.
    int m_pc, m_ifpc, m_ifpc4;
    bit m_boot, m_hold, m_valid;
    logic [31:0] m_instr;
    int m_fetched, m_bubbles;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_boot = 1; m_hold = 0; m_valid = 0; m_instr = 32'h0;
            m_ifpc = 0; m_ifpc4 = 0; m_fetched = 0; m_bubbles = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (branch_taken) begin
            m_pc = (int'(branch_target) / 4) * 4;
            m_valid = 0; m_instr = 32'h0; m_hold = 0;
            m_bubbles++;
        end else if (stall) begin
            m_hold = 1;
            m_bubbles++;
        end else begin
            m_valid = 1;
            m_instr = mem[m_pc / 4];
            m_ifpc  = m_pc;
            m_ifpc4 = (m_pc + 4) % 512;
            m_pc    = (m_pc + 4) % 512;
            m_hold  = 0;
            m_fetched++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        int st;
        st = m_boot ? 0 : (m_hold ? 2 : 1);
        chk({tag, ".addr"},  32'(imem_addr),      32'(m_pc));
        chk({tag, ".valid"}, 32'(if_id_valid),    32'(m_valid));
        chk({tag, ".instr"}, if_id_instr,         m_instr);
        chk({tag, ".pc"},    32'(if_id_pc),       32'(m_ifpc));
        chk({tag, ".pc4"},   32'(if_id_pc_plus4), 32'(m_ifpc4));
        chk({tag, ".state"}, 32'(fetch_state),    32'(st));
`ifdef FETCH_PERF_EN
        chk({tag, ".fetched"}, 32'(perf_fetched), 32'(m_fetched));
        chk({tag, ".bubbles"}, 32'(perf_bubbles), 32'(m_bubbles));
`endif
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) compare_model("cyc");
    end

    task automatic edge_sample();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".valid"}, 32'(if_id_valid),    32'h0);
        chk({tag, ".instr"}, if_id_instr,         32'h0);
        chk({tag, ".pc"},    32'(if_id_pc),       32'h0);
        chk({tag, ".pc4"},   32'(if_id_pc_plus4), 32'h0);
        chk({tag, ".addr"},  32'(imem_addr),      32'h0);
        chk({tag, ".state"}, 32'(fetch_state),    32'h0);
`ifdef FETCH_PERF_EN
        chk({tag, ".fetched"}, 32'(perf_fetched), 32'h0);
        chk({tag, ".bubbles"}, 32'(perf_bubbles), 32'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        mem[3] = 32'h4444_4444;

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 9'd0;
        #3;
        check_reset_values("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1;

        edge_sample();
        chk("boot.valid", 32'(if_id_valid), 32'h0);
        chk("boot.state", 32'(fetch_state), 32'd1);
        edge_sample();
        chk("e2.instr", if_id_instr, 32'h1111_1111);
        chk("e2.pc",    32'(if_id_pc), 32'd0);
        chk("e2.pc4",   32'(if_id_pc_plus4), 32'd4);
        edge_sample();
        chk("e3.instr", if_id_instr, 32'h2222_2222);
        chk("e3.pc",    32'(if_id_pc), 32'd4);

        @(negedge clk); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            chk("stall.instr", if_id_instr, 32'h2222_2222);
            chk("stall.addr",  32'(imem_addr), 32'd8);
            chk("stall.state", 32'(fetch_state), 32'd2);
        end
        @(negedge clk); stall = 1'b0;
        edge_sample();
        chk("resume.instr", if_id_instr, 32'h3333_3333);
        chk("resume.pc",    32'(if_id_pc), 32'd8);

        @(negedge clk); branch_taken = 1'b1; branch_target = 9'd13;
        edge_sample();
        chk("br.addr",  32'(imem_addr), 32'd12);
        chk("br.valid", 32'(if_id_valid), 32'h0);
        chk("br.instr", if_id_instr, 32'h0);
        chk("br.pc_hold", 32'(if_id_pc), 32'd8);
        @(negedge clk); branch_taken = 1'b0;
        edge_sample();
        chk("br2.instr", if_id_instr, 32'h4444_4444);
        chk("br2.pc",    32'(if_id_pc), 32'd12);

        @(negedge clk); stall = 1'b1;
        edge_sample();
        @(negedge clk); branch_taken = 1'b1; branch_target = 9'd42;
        edge_sample();
        chk("bs.addr",  32'(imem_addr), 32'd40);
        chk("bs.valid", 32'(if_id_valid), 32'h0);
        chk("bs.state", 32'(fetch_state), 32'd1);
        @(negedge clk); stall = 1'b0; branch_taken = 1'b1; branch_target = 9'd510;
        edge_sample();
        chk("wrap.addr", 32'(imem_addr), 32'd508);
        @(negedge clk); branch_taken = 1'b0;
        edge_sample();
        chk("wrap.pc",  32'(if_id_pc), 32'd508);
        chk("wrap.pc4", 32'(if_id_pc_plus4), 32'd0);
        chk("wrap.addr0", 32'(imem_addr), 32'd0);
        edge_sample();
        chk("wrap2.pc",    32'(if_id_pc), 32'd0);
        chk("wrap2.instr", if_id_instr, 32'h1111_1111);

        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk); rst_n = 1'b1;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            stall         = ($urandom_range(0, 99) < 30);
            branch_taken  = ($urandom_range(0, 99) < 15);
            branch_target = 9'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                #1 rst_n = 1'b0;
                #1 compare_model("rrst");
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        cmp_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
